mult_issue: RTL and testbench

Operand-issue and result-return sequencer placed directly upstream of the multiplier control FSM. It accepts an 8-bit × 8-bit operand pair over a valid/ready handshake and holds the operands stable for the nibble datapath. It drives the control FSM's `start` pulse and 2-bit `count` sequence, waits for its `done` pulse, then returns the 16-bit product over a second valid/ready handshake. A watchdog flags a controller that never completes.

---
 rtl/mult_issue.sv | 168 ++++++++++++++++
 tb/tb_mult_issue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue.sv
`default_nettype none
// ============================================================================
// Module      : mult_issue
// Description : Operand-issue and result-return sequencer for the nibble
//               multiplier. Accepts an 8x8 operand pair (valid/ready), holds
//               it on dataa/datab, sequences the control FSM with a one-cycle
//               start pulse followed by count 00..11, waits for done, then
//               offers the captured 16-bit product (valid/ready). A watchdog
//               parks the block in an error state if done never arrives.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock, rising edge
//   reset_a      in   asynchronous reset, active low
//   op_valid     in   operand pair offered
//   op_ready     out  operand pair can be accepted (IDLE only)
//   op_a, op_b   in   multiplicand / multiplier
//   dataa, datab out  latched operands, stable between acceptances
//   start        out  start request to the control FSM
//   count        out  nibble-step index to the control FSM
//   done         in   one-cycle completion pulse from the control FSM
//   product_in   in   accumulator output of the datapath
//   res_valid    out  product available
//   res_ready    in   consumer takes the product
//   res_product  out  captured product
//   busy         out  operation in flight (START/RUN/WAIT/HOLD)
//   err          out  watchdog fired, held until err_clr
//   err_clr      in   leave the error state
// ============================================================================
module mult_issue #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic [7:0]  dataa,
    output logic [7:0]  datab,
    output logic        start,
    output logic [1:0]  count,
    input  logic        done,
    input  logic [15:0] product_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_product,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    // Last wait-counter value before the watchdog gives up.
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_step;
    logic [7:0]  r_wait;
    logic [7:0]  r_dataa;
    logic [7:0]  r_datab;
    logic [15:0] r_res_product;
    logic        w_accept;
    logic        w_capture;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (r_step == 2'd3) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // done takes priority over an expiring watchdog
                if (done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (r_wait == c_wait_last) begin
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (err_clr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Step / wait counters and data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_step        <= 2'd0;
            r_wait        <= 8'd0;
            r_dataa       <= 8'd0;
            r_datab       <= 8'd0;
            r_res_product <= 16'd0;
        end else begin
            // Step counter wraps 3 -> 0 on the RUN -> WAIT transition.
            r_step <= (r_state == ST_RUN) ? r_step + 2'd1 : 2'd0;
            r_wait <= (r_state == ST_WAIT) ? r_wait + 8'd1 : 8'd0;
            if (w_accept) begin
                r_dataa <= op_a;
                r_datab <= op_b;
            end
            if (w_capture) begin
                r_res_product <= product_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state registers only
    // ------------------------------------------------------------------
    assign op_ready    = (r_state == ST_IDLE);
    assign start       = (r_state == ST_START);
    assign count       = (r_state == ST_RUN) ? r_step : 2'b00;
    assign res_valid   = (r_state == ST_HOLD);
    assign busy        = (r_state == ST_START) || (r_state == ST_RUN) ||
                         (r_state == ST_WAIT)  || (r_state == ST_HOLD);
    assign err         = (r_state == ST_ERROR);
    assign dataa       = r_dataa;
    assign datab       = r_datab;
    assign res_product = r_res_product;

endmodule
`default_nettype wire

// File: tb/tb_mult_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_issue
// Description : Self-checking bench for mult_issue. Models a conforming
//               control FSM (done after a chosen number of cycles) and the
//               datapath (product only valid while done is high), applies a
//               vector table, hand sequences and randomized operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_issue;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        op_valid = 1'b0;
    logic [7:0]  op_a = 8'd0;
    logic [7:0]  op_b = 8'd0;
    logic        done = 1'b0;
    logic [15:0] product_in = 16'hBAD0;
    logic        res_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        op_ready, start, res_valid, busy, err;
    logic [7:0]  dataa, datab;
    logic [1:0]  count;
    logic [15:0] res_product;

    int errors = 0;
    int checks = 0;
    int c = -1;          // cycles since the start pulse was seen
    int done_at = 6;     // value of c during which done is driven
    bit extra_done = 1'b0;

    mult_issue #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_a(reset_a), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .dataa(dataa), .datab(datab),
        .start(start), .count(count), .done(done), .product_in(product_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; sample point is 1 time unit after the rising edge.
    // Controller/datapath model updates its drive for the coming cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (start) c = 0;
        else if (c >= 0) c++;
        done       = (c == done_at) || extra_done;
        extra_done = 1'b0;
        product_in = done ? (16'(dataa) * 16'(datab)) : 16'hBAD0;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          dat;
        int          hold;
        bit          spur;
        bit          exp_err;
        logic [15:0] exp_prod;
    } vec_t;

    // One complete operation, checked cycle by cycle against the timing rules:
    // start at acceptance, count 0..3 in cycles 1..4, result at dat+1 edges,
    // or err at 5+TO edges when done comes too late.
    task automatic run_op(input vec_t v);
        int end_n;
        int w;
        done_at   = v.dat;
        res_ready = 1'b0;
        w = 0;
        while (!op_ready && w < 40) begin tick(); w++; end
        chk("ready_before_issue", op_ready, 1);
        if (v.spur) begin
            extra_done = 1'b1;          // done pulse while IDLE
            tick();
            tick();
            chk("idle_done_ignored_ready", op_ready, 1);
            chk("idle_done_ignored_valid", res_valid, 0);
        end
        op_valid = 1'b1; op_a = v.a; op_b = v.b;
        tick();
        op_valid = 1'b0; op_a = 8'h00; op_b = 8'h00;
        chk("accept_start", start, 1);
        chk("accept_busy", busy, 1);
        chk("accept_ready", op_ready, 0);
        chk("accept_dataa", dataa, v.a);
        chk("accept_datab", datab, v.b);
        end_n = v.exp_err ? 5 + TO : v.dat + 1;
        for (int n = 1; n < end_n; n++) begin
            if (v.spur && n == 2) begin op_valid = 1'b1; op_a = 8'h55; op_b = 8'h55; end
            if (v.spur && n == 3) extra_done = 1'b1;   // done pulse during RUN
            if (n == 5) begin op_valid = 1'b0; op_a = 8'h00; op_b = 8'h00; end
            tick();
            chk("run_count", count, (n <= 4) ? n - 1 : 0);
            chk("run_start", start, 0);
            chk("run_busy", busy, 1);
            chk("run_res_valid", res_valid, 0);
            chk("run_err", err, 0);
            chk("run_dataa", dataa, v.a);
        end
        op_valid = 1'b0;
        tick();
        if (!v.exp_err) begin
            chk("res_valid_rise", res_valid, 1);
            chk("res_product", res_product, v.exp_prod);
            chk("hold_busy", busy, 1);
            chk("hold_ready", op_ready, 0);
            for (int h = 0; h < v.hold; h++) begin
                tick();
                chk("bp_res_valid", res_valid, 1);
                chk("bp_res_product", res_product, v.exp_prod);
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk("ret_res_valid", res_valid, 0);
            chk("ret_busy", busy, 0);
            chk("ret_op_ready", op_ready, 1);
            chk("ret_dataa_kept", dataa, v.a);
        end else begin
            chk("wd_err", err, 1);
            chk("wd_op_ready", op_ready, 0);
            chk("wd_busy", busy, 0);
            chk("wd_start", start, 0);
            chk("wd_count", count, 0);
            chk("wd_res_valid", res_valid, 0);
            op_valid = 1'b1; op_a = 8'hC3; op_b = 8'h3C;
            tick();
            tick();
            op_valid = 1'b0;
            chk("wd_err_sticky", err, 1);
            chk("wd_dataa_kept", dataa, v.a);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            chk("wd_cleared_err", err, 0);
            chk("wd_cleared_ready", op_ready, 1);
        end
    endtask

    vec_t tbl [8];
    logic [7:0] ba [3];
    logic [7:0] bb [3];

    initial begin
        //          a      b      dat   hold spur err  product
        tbl[0] = '{8'h0F, 8'h0B, 6,    0,   0,   0,   16'h00A5};  // basic
        tbl[1] = '{8'hFF, 8'hFF, 6,    10,  0,   0,   16'hFE01};  // backpressure
        tbl[2] = '{8'hA5, 8'h5A, 1000, 0,   0,   1,   16'h0000};  // watchdog
        tbl[3] = '{8'h21, 8'h43, 6,    0,   1,   0,   16'h08A3};  // spurious events
        tbl[4] = '{8'h00, 8'hFF, 5,    1,   0,   0,   16'h0000};  // done in first WAIT cycle
        tbl[5] = '{8'h81, 8'h7E, 19,   0,   0,   0,   16'h3F7E};  // done on last WAIT cycle
        tbl[6] = '{8'h11, 8'h22, 20,   0,   0,   1,   16'h0000};  // done one cycle too late
        tbl[7] = '{8'hC0, 8'h03, 9,    2,   0,   0,   16'h0240};

        // Asynchronous reset, checked before any clock edge.
        #2 reset_a = 1'b0;
        #1;
        chk("rst_start", start, 0);
        chk("rst_count", count, 0);
        chk("rst_dataa", dataa, 0);
        chk("rst_datab", datab, 0);
        chk("rst_res_product", res_product, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_ready", op_ready, 1);
        tick();
        tick();
        reset_a = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_op(tbl[i]);

        // Reset in the third RUN cycle drops outputs without a clock edge.
        done_at = 6;
        op_valid = 1'b1; op_a = 8'h77; op_b = 8'h22;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_count", count, 2);
        #2 reset_a = 1'b0;
        #1;
        chk("mid_rst_start", start, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_dataa", dataa, 0);
        chk("mid_rst_op_ready", op_ready, 1);
        tick();
        reset_a = 1'b1;
        c = -1;
        tick();
        run_op('{8'h12, 8'h34, 6, 0, 0, 0, 16'h03A8});

        // Back-to-back: op_valid and res_ready held high.
        begin
            int acc;
            int got;
            ba[0] = 8'h13; bb[0] = 8'hF1;
            ba[1] = 8'hEE; bb[1] = 8'h02;
            ba[2] = 8'h9A; bb[2] = 8'hB7;
            acc = 0;
            got = 0;
            done_at = 6;
            res_ready = 1'b1;
            op_valid = 1'b1; op_a = ba[0]; op_b = bb[0];
            for (int e = 0; e < 40 && got < 3; e++) begin
                tick();
                if (start) begin
                    chk("b2b_accept_edge", e, acc * 9);
                    if (acc < 3) chk("b2b_dataa", dataa, ba[acc]);
                    acc++;
                    if (acc < 3) begin op_a = ba[acc]; op_b = bb[acc]; end
                end
                if (res_valid) begin
                    if (got < 3) chk("b2b_product", res_product, 16'(ba[got]) * 16'(bb[got]));
                    got++;
                end
            end
            chk("b2b_completions", got, 3);
            op_valid = 1'b0;
            tick();
            res_ready = 1'b0;
            chk("b2b_idle", op_ready, 1);
        end

        // Randomized operations against the timing/arithmetic model.
        for (int r = 0; r < 25; r++) begin
            vec_t v;
            v.a       = 8'($urandom);
            v.b       = 8'($urandom);
            v.dat     = int'($urandom_range(5, 5 + TO));
            v.hold    = int'($urandom_range(0, 3));
            v.spur    = (v.dat == 6) ? 1'($urandom) : 1'b0;
            v.exp_err = (v.dat > 4 + TO);
            v.exp_prod = v.exp_err ? 16'h0000 : 16'(v.a) * 16'(v.b);
            run_op(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
